// File: rtl/i2c_slave_link.sv
// rtl/i2c_slave_link.sv - I2C 7-bit slave byte link (optional general call: I2C_SLAVE_LINK_GCALL_EN)
module i2c_slave_link #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] address,
    input  logic [7:0] datasend,
    output logic       sended,
    output logic [7:0] datareceive,
    output logic       received
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK} state_t;

    state_t                state;
    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-1:0] scl_hist, sda_hist;
    logic                  scl_f, sda_f, scl_d, sda_d;
    logic [6:0]            shift;
    logic [7:0]            tx_shift;
    logic [3:0]            bit_cnt;
    logic                  rw, ack_phase;

    logic       scl_rise, scl_fall, start_c, stop_c, addr_match;
    logic [7:0] shift_next;

    assign scl_rise   = scl_f & ~scl_d;
    assign scl_fall   = ~scl_f & scl_d;
    assign start_c    = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_c     = scl_f & scl_d & ~sda_d & sda_f;
    assign shift_next = {shift, sda_f};

`ifdef I2C_SLAVE_LINK_GCALL_EN
    assign addr_match = (shift_next[7:1] == address) || (shift_next == 8'h00);
`else
    assign addr_match = (shift_next[7:1] == address);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            scl_sync    <= '1;
            sda_sync    <= '1;
            scl_hist    <= '1;
            sda_hist    <= '1;
            scl_f       <= 1'b1;
            sda_f       <= 1'b1;
            scl_d       <= 1'b1;
            sda_d       <= 1'b1;
            shift       <= '0;
            tx_shift    <= '0;
            bit_cnt     <= '0;
            rw          <= 1'b0;
            ack_phase   <= 1'b0;
            sda_oe      <= 1'b0;
            sended      <= 1'b0;
            received    <= 1'b0;
            datareceive <= 8'h00;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
            sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
            // A level is accepted only once the whole history agrees
            if (&scl_hist) scl_f <= 1'b1;
            else if (~|scl_hist) scl_f <= 1'b0;
            if (&sda_hist) sda_f <= 1'b1;
            else if (~|sda_hist) sda_f <= 1'b0;
            scl_d <= scl_f;
            sda_d <= sda_f;

            if (start_c || stop_c) begin
                state     <= start_c ? ADDR : IDLE;
                bit_cnt   <= '0;
                shift     <= '0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                received  <= 1'b0;
                sended    <= 1'b0;
            end else begin
                if (scl_fall) begin
                    received <= 1'b0;
                    sended   <= 1'b0;
                end
                case (state)
                    ADDR: if (scl_rise) begin
                        shift   <= shift_next[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt   <= '0;
                            rw        <= sda_f;
                            ack_phase <= 1'b0;
                            state     <= addr_match ? ADDR_ACK : IDLE;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            if (rw) begin
                                // First data bit goes out on the same falling edge that ends the ACK
                                tx_shift <= {datasend[6:0], 1'b0};
                                sda_oe   <= ~datasend[7];
                                bit_cnt  <= 4'd1;
                                state    <= TX;
                            end else begin
                                sda_oe   <= 1'b0;
                                bit_cnt  <= '0;
                                state    <= RX;
                            end
                        end
                    end
                    RX: if (scl_rise) begin
                        shift   <= shift_next[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            datareceive <= shift_next;
                            received    <= 1'b1;
                            bit_cnt     <= '0;
                            ack_phase   <= 1'b0;
                            state       <= RX_ACK;
                        end
                    end
                    RX_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            sda_oe    <= 1'b0;
                            ack_phase <= 1'b0;
                            state     <= RX;
                        end
                    end
                    TX: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe    <= 1'b0;
                            bit_cnt   <= '0;
                            ack_phase <= 1'b0;
                            state     <= TX_ACK;
                        end else begin
                            sda_oe   <= ~tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            sended <= 1'b1;
                            if (sda_f) state <= IDLE;
                            else ack_phase <= 1'b1;
                        end else if (scl_fall && ack_phase) begin
                            tx_shift  <= {datasend[6:0], 1'b0};
                            sda_oe    <= ~datasend[7];
                            bit_cnt   <= 4'd1;
                            ack_phase <= 1'b0;
                            state     <= TX;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_link.sv
// tb/tb_i2c_slave_link.sv - directed and randomized master transactions against a transaction-level slave model
module tb_i2c_slave_link;
    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_oe;
    logic [6:0] address;
    logic [7:0] datasend;
    logic       sended;
    logic [7:0] datareceive;
    logic       received;
    wire        sda_line = sda_m & ~sda_oe;

    int checks = 0;
    int errors = 0;
    int rcv_pulses = 0;
    int snd_pulses = 0;
    logic both_seen = 1'b0;
    logic rcv_prev = 1'b0, snd_prev = 1'b0, oe_prev = 1'b0;

    i2c_slave_link #(.FILTER_LEN(3)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .address(address), .datasend(datasend), .sended(sended),
        .datareceive(datareceive), .received(received)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        rcv_prev <= received;
        snd_prev <= sended;
        oe_prev  <= sda_oe;
        if (received && !rcv_prev) rcv_pulses++;
        if (sended && !snd_prev) snd_pulses++;
        if (received && sended) both_seen = 1'b1;
        if (sda_oe && !oe_prev) check("oe_rise_scl_low", {7'b0, scl}, 8'h00);
    end

    function automatic logic model_ack(input logic [7:0] b, input logic [6:0] own);
        logic gc;
        gc = 1'b0;
`ifdef I2C_SLAVE_LINK_GCALL_EN
        gc = (b == 8'h00);
`endif
        return (b[7:1] == own) || gc;
    endfunction

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wq(); scl = 1'b1; wq(); sda_m = 1'b0; wq(); scl = 1'b0; wq();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wq(); scl = 1'b1; wq(); sda_m = 1'b1; wq();
    endtask

    task automatic bit_cycle(input logic drive, output logic line, output logic oe);
        sda_m = drive; wq(); scl = 1'b1; wq();
        line = sda_line; oe = sda_oe;
        wq(); scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic line, oe;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], line, oe);
        bit_cycle(1'b1, line, oe);
        acked = oe;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack, input logic [7:0] next_ds);
        logic line, oe;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, line, oe);
            d[i] = line;
        end
        datasend = next_ds;
        bit_cycle(nack, line, oe);
    endtask

    logic       ack, a2, exp_ack, match, rw, line, oe;
    logic [7:0] d, ab, exp_dr, ds;
    int         exp_rcv, exp_snd, nbytes;

    initial begin
        reset = 1'b0; scl = 1'b1; sda_m = 1'b1; address = 7'h3C; datasend = 8'h00;
        exp_dr = 8'h00; exp_rcv = 0; exp_snd = 0;
        repeat (5) @(negedge clk);
        check("reset_sda_oe", {7'b0, sda_oe}, 8'h00);
        check("reset_received", {7'b0, received}, 8'h00);
        check("reset_sended", {7'b0, sended}, 8'h00);
        check("reset_datareceive", datareceive, 8'h00);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Write 0xA5 to own address
        bus_start();
        write_byte(8'h78, ack); check("w_addr_ack", {7'b0, ack}, 8'h01);
        write_byte(8'hA5, ack); check("w_data_ack", {7'b0, ack}, 8'h01);
        bus_stop();
        exp_dr = 8'hA5; exp_rcv++;
        check("w_datareceive", datareceive, exp_dr);
        check("w_rcv_pulses", rcv_pulses[7:0], exp_rcv[7:0]);
        check("w_snd_pulses", snd_pulses[7:0], exp_snd[7:0]);

        // Foreign address: nothing acked, following bytes ignored
        bus_start();
        write_byte(8'h7A, ack); check("nm_addr_ack", {7'b0, ack}, 8'h00);
        write_byte(8'h78, ack); check("nm_data_ack", {7'b0, ack}, 8'h00);
        write_byte(8'h55, ack); check("nm_data2_ack", {7'b0, ack}, 8'h00);
        bus_stop();
        check("nm_datareceive", datareceive, exp_dr);
        check("nm_rcv_pulses", rcv_pulses[7:0], exp_rcv[7:0]);

        // Read two bytes; datasend changes between them
        datasend = 8'h5A;
        bus_start();
        write_byte(8'h79, ack); check("r_addr_ack", {7'b0, ack}, 8'h01);
        read_byte(d, 1'b0, 8'hC3); check("r_byte0", d, 8'h5A);
        read_byte(d, 1'b1, 8'hC3); check("r_byte1", d, 8'hC3);
        exp_snd += 2;
        check("r_oe_after_nack", {7'b0, sda_oe}, 8'h00);
        write_byte(8'h78, ack); check("r_idle_after_nack", {7'b0, ack}, 8'h00);
        bus_stop();
        check("r_snd_pulses", snd_pulses[7:0], exp_snd[7:0]);
        check("r_rcv_pulses", rcv_pulses[7:0], exp_rcv[7:0]);

        // Partial byte cut by STOP
        bus_start();
        write_byte(8'h78, ack); check("p_addr_ack", {7'b0, ack}, 8'h01);
        for (int i = 0; i < 4; i++) bit_cycle(i[0], line, oe);
        bus_stop();
        check("p_datareceive", datareceive, exp_dr);
        check("p_rcv_pulses", rcv_pulses[7:0], exp_rcv[7:0]);
        check("p_sda_oe", {7'b0, sda_oe}, 8'h00);

        // General call write
        bus_start();
        write_byte(8'h00, ack);
        exp_ack = model_ack(8'h00, address);
        check("gc_addr_ack", {7'b0, ack}, {7'b0, exp_ack});
        write_byte(8'h11, a2);
        check("gc_data_ack", {7'b0, a2}, {7'b0, exp_ack});
        bus_stop();
        if (exp_ack) begin exp_dr = 8'h11; exp_rcv++; end
        check("gc_datareceive", datareceive, exp_dr);
        check("gc_rcv_pulses", rcv_pulses[7:0], exp_rcv[7:0]);

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            address = 7'($urandom_range(1, 127));
            match   = 1'($urandom_range(0, 1));
            rw      = 1'($urandom_range(0, 1));
            ab      = match ? {address, rw} : {7'($urandom), rw};
            nbytes  = $urandom_range(1, 3);
            exp_ack = model_ack(ab, address);
            datasend = 8'($urandom);
            bus_start();
            write_byte(ab, ack);
            check("rnd_addr_ack", {7'b0, ack}, {7'b0, exp_ack});
            if (exp_ack && !ab[0]) begin
                for (int k = 0; k < nbytes; k++) begin
                    d = 8'($urandom);
                    write_byte(d, ack);
                    check("rnd_wr_ack", {7'b0, ack}, 8'h01);
                    exp_dr = d; exp_rcv++;
                end
            end else if (exp_ack) begin
                for (int k = 0; k < nbytes; k++) begin
                    ds = datasend;
                    read_byte(d, (k == nbytes - 1), 8'($urandom));
                    check("rnd_rd_byte", d, ds);
                    exp_snd++;
                end
            end
            bus_stop();
            check("rnd_datareceive", datareceive, exp_dr);
            check("rnd_rcv_pulses", rcv_pulses[7:0], exp_rcv[7:0]);
            check("rnd_snd_pulses", snd_pulses[7:0], exp_snd[7:0]);
        end
        address = 7'h3C;

        // Reset in the middle of a read while SDA is pulled low
        datasend = 8'h00;
        bus_start();
        write_byte(8'h79, ack); check("rst_addr_ack", {7'b0, ack}, 8'h01);
        bit_cycle(1'b1, line, oe);
        bit_cycle(1'b1, line, oe);
        check("rst_oe_before", {7'b0, sda_oe}, 8'h01);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst_oe_released", {7'b0, sda_oe}, 8'h00);
        check("rst_received", {7'b0, received}, 8'h00);
        check("rst_sended", {7'b0, sended}, 8'h00);
        check("rst_datareceive", datareceive, 8'h00);
        @(negedge clk); reset = 1'b1;
        exp_dr = 8'h00;
        bit_cycle(1'b1, line, oe);
        check("rst_ignores_bus", {7'b0, sda_oe}, 8'h00);
        bus_stop();
        bus_start();
        write_byte(8'h78, ack); check("post_rst_addr_ack", {7'b0, ack}, 8'h01);
        write_byte(8'h3C, ack); check("post_rst_data_ack", {7'b0, ack}, 8'h01);
        bus_stop();
        exp_dr = 8'h3C; exp_rcv++;
        check("post_rst_datareceive", datareceive, exp_dr);
        check("post_rst_rcv_pulses", rcv_pulses[7:0], exp_rcv[7:0]);
        check("never_both_high", {7'b0, both_seen}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
